// File: rtl/mlp_host_seq_if.sv
// Host-side command/source bus, MLP controller request/data/result bus and
// status outputs of the MLP host sequencer, bundled for a single port.
interface mlp_host_seq_if #(
  parameter int DataWidth = 8
);
  logic                 cmd_valid_i;
  logic                 cmd_ready_o;
  logic                 cmd_op_i;
  logic                 src_valid_i;
  logic                 src_ready_o;
  logic [DataWidth-1:0] src_data_i;
  logic                 mlp_init_valid_o;
  logic                 mlp_init_ready_i;
  logic                 mlp_start_valid_o;
  logic                 mlp_start_ready_i;
  logic [DataWidth-1:0] mlp_data_o;
  logic                 mlp_result_valid_i;
  logic [DataWidth-1:0] mlp_result_data_i;
  logic                 res_valid_o;
  logic [DataWidth-1:0] res_data_o;
  logic [7:0]           res_idx_o;
  logic                 busy_o;
  logic                 done_o;
  logic                 err_o;

  modport master (
    output cmd_valid_i, cmd_op_i, src_valid_i, src_data_i,
           mlp_init_ready_i, mlp_start_ready_i, mlp_result_valid_i, mlp_result_data_i,
    input  cmd_ready_o, src_ready_o, mlp_init_valid_o, mlp_start_valid_o, mlp_data_o,
           res_valid_o, res_data_o, res_idx_o, busy_o, done_o, err_o
  );

  modport slave (
    input  cmd_valid_i, cmd_op_i, src_valid_i, src_data_i,
           mlp_init_ready_i, mlp_start_ready_i, mlp_result_valid_i, mlp_result_data_i,
    output cmd_ready_o, src_ready_o, mlp_init_valid_o, mlp_start_valid_o, mlp_data_o,
           res_valid_o, res_data_o, res_idx_o, busy_o, done_o, err_o
  );
endinterface

// File: rtl/mlp_host_seq.sv
// Host sequencer for an MLP controller: streams weight or activation bursts
// into the controller, then collects the result stream of an inference run.
module mlp_host_seq #(
  parameter int DataWidth = 8,
  parameter int WordsW    = 2048,
  parameter int WordsX    = 256
) (
  input logic            clk_i,
  input logic            rst_ni,
  mlp_host_seq_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, W_REQ, W_STREAM, X_REQ, X_STREAM, R_WAIT, R_COLLECT} state_t;

  localparam logic [10:0] LastW = 11'(WordsW - 1);
  localparam logic [10:0] LastX = 11'(WordsX - 1);

  state_t               state_q, state_d;
  logic [10:0]          cnt_q;
  logic                 err_q, done_q, res_valid_q;
  logic [DataWidth-1:0] res_data_q;
  logic [7:0]           res_idx_q;

  logic                 cmd_ready, src_ready, init_valid, start_valid, streaming;
  logic [DataWidth-1:0] mlp_data;
  logic                 collecting, capture, accept;

  assign collecting = (state_q == R_WAIT) || (state_q == R_COLLECT);
  assign capture    = collecting && bus.mlp_result_valid_i;
  assign accept     = (state_q == IDLE) && bus.cmd_valid_i;

  always_comb begin
    state_d     = state_q;
    cmd_ready   = 1'b0;
    src_ready   = 1'b0;
    init_valid  = 1'b0;
    start_valid = 1'b0;
    streaming   = 1'b0;
    mlp_data    = '0;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (bus.cmd_valid_i) state_d = bus.cmd_op_i ? X_REQ : W_REQ;
      end
      W_REQ: begin
        init_valid = 1'b1;
        if (bus.mlp_init_ready_i) state_d = W_STREAM;
      end
      X_REQ: begin
        start_valid = 1'b1;
        if (bus.mlp_start_ready_i) state_d = X_STREAM;
      end
      W_STREAM: begin
        streaming = 1'b1;
        if (cnt_q == LastW) state_d = IDLE;
      end
      X_STREAM: begin
        streaming = 1'b1;
        if (cnt_q == LastX) state_d = R_WAIT;
      end
      R_WAIT: begin
        if (bus.mlp_result_valid_i) state_d = (LastX == 11'd0) ? IDLE : R_COLLECT;
      end
      R_COLLECT: begin
        if (bus.mlp_result_valid_i && cnt_q == LastX) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Underrun words are replaced by zero so the burst never stalls.
    if (streaming) begin
      src_ready = 1'b1;
      mlp_data  = bus.src_valid_i ? bus.src_data_i : '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      res_valid_q <= capture;
      done_q      <= ((state_q == W_STREAM) && (cnt_q == LastW)) ||
                     (capture && (cnt_q == LastX));
      if (capture) begin
        res_data_q <= bus.mlp_result_data_i;
        res_idx_q  <= cnt_q[7:0];
      end
      // One counter serves both the source burst and the result count.
      if (accept)         cnt_q <= '0;
      else if (streaming) cnt_q <= (state_d == state_q) ? cnt_q + 11'd1 : '0;
      else if (capture)   cnt_q <= cnt_q + 11'd1;
      if (accept) err_q <= 1'b0;
      if ((streaming && !bus.src_valid_i) || (bus.mlp_result_valid_i && !collecting))
        err_q <= 1'b1;
    end
  end

  assign bus.cmd_ready_o       = cmd_ready;
  assign bus.src_ready_o       = src_ready;
  assign bus.mlp_init_valid_o  = init_valid;
  assign bus.mlp_start_valid_o = start_valid;
  assign bus.mlp_data_o        = mlp_data;
  assign bus.res_valid_o       = res_valid_q;
  assign bus.res_data_o        = res_data_q;
  assign bus.res_idx_o         = res_idx_q;
  assign bus.busy_o            = (state_q != IDLE);
  assign bus.done_o            = done_q;
  assign bus.err_o             = err_q;
endmodule

// File: tb/tb_mlp_host_seq.sv
// Directed bench for mlp_host_seq: weight load with delayed init handshake,
// inference runs with result collection, underrun, mid-burst reset, spurious results.
module tb_mlp_host_seq;
  localparam int DW = 8;
  localparam int NW = 2048;
  localparam int NX = 256;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mlp_host_seq_if #(.DataWidth(DW)) bus ();
  mlp_host_seq #(.DataWidth(DW), .WordsW(NW), .WordsX(NX)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic       cv, op, ir, sv;
    logic [7:0] sd;
    logic       e_cr, e_iv, e_stv, e_sr, e_busy;
    logic [7:0] e_md;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic op);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_op_i    = op;
    #1;
    chk("cmd_ready_idle", bus.cmd_ready_o, 1);
    chk("busy_idle", bus.busy_o, 0);
    tick();
    bus.cmd_valid_i = 1'b0;
    chk("busy_after_cmd", bus.busy_o, 1);
    chk("cmd_ready_busy", bus.cmd_ready_o, 0);
    chk("err_cleared_by_cmd", bus.err_o, 0);
  endtask

  task automatic hs_start();
    bus.mlp_start_ready_i = 1'b1;
    #1;
    chk("start_valid", bus.mlp_start_valid_o, 1);
    chk("init_low_in_xreq", bus.mlp_init_valid_o, 0);
    tick();
    bus.mlp_start_ready_i = 1'b0;
  endtask

  task automatic stream(input int n, input int drop_at, input bit is_w);
    for (int k = 0; k < n; k++) begin
      bus.src_valid_i = (k != drop_at);
      bus.src_data_i  = 8'(k);
      #1;
      chk("src_ready_stream", bus.src_ready_o, 1);
      chk("mlp_data", bus.mlp_data_o, (k == drop_at) ? 0 : (k & 255));
      chk("no_req_in_stream", {bus.mlp_init_valid_o, bus.mlp_start_valid_o}, 0);
      tick();
      chk("err_stream", bus.err_o, (drop_at >= 0 && k >= drop_at) ? 1 : 0);
      chk("done_stream", bus.done_o, (is_w && k == n - 1) ? 1 : 0);
    end
    bus.src_valid_i = 1'b0;
  endtask

  task automatic results(input int gap_at);
    for (int i = 0; i < NX; i++) begin
      if (i == gap_at) begin
        bus.mlp_result_valid_i = 1'b0;
        tick();
        chk("res_valid_gap", bus.res_valid_o, 0);
      end
      bus.mlp_result_valid_i = 1'b1;
      bus.mlp_result_data_i  = 8'(255 - i);
      tick();
      chk("res_valid", bus.res_valid_o, 1);
      chk("res_idx", bus.res_idx_o, i);
      chk("res_data", bus.res_data_o, 255 - i);
      chk("res_done", bus.done_o, (i == NX - 1) ? 1 : 0);
    end
    bus.mlp_result_valid_i = 1'b0;
    chk("idle_after_results", bus.busy_o, 0);
    tick();
    chk("res_valid_end", bus.res_valid_o, 0);
    chk("done_end", bus.done_o, 0);
  endtask

  initial begin
    bus.cmd_valid_i        = 1'b0;
    bus.cmd_op_i           = 1'b0;
    bus.src_valid_i        = 1'b1;
    bus.src_data_i         = 8'hA5;
    bus.mlp_init_ready_i   = 1'b0;
    bus.mlp_start_ready_i  = 1'b0;
    bus.mlp_result_valid_i = 1'b0;
    bus.mlp_result_data_i  = '0;

    // Reset state
    #3;
    chk("rst_cmd_ready", bus.cmd_ready_o, 1);
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_src_ready", bus.src_ready_o, 0);
    chk("rst_mlp_data", bus.mlp_data_o, 0);
    chk("rst_reqs", {bus.mlp_init_valid_o, bus.mlp_start_valid_o}, 0);
    chk("rst_res", {bus.res_valid_o, bus.done_o, bus.err_o}, 0);
    chk("rst_res_data", {bus.res_data_o, bus.res_idx_o}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.src_valid_i = 1'b0;
    tick();

    // Weight load: init ready held low 5 cycles, then handshake
    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    for (int i = 1; i < 6; i++)
      tbl[i] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00};
    tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00};
    for (int i = 0; i < 7; i++) begin
      bus.cmd_valid_i      = tbl[i].cv;
      bus.cmd_op_i         = tbl[i].op;
      bus.mlp_init_ready_i = tbl[i].ir;
      bus.src_valid_i      = tbl[i].sv;
      bus.src_data_i       = tbl[i].sd;
      #1;
      chk("tbl_cmd_ready", bus.cmd_ready_o, tbl[i].e_cr);
      chk("tbl_init_valid", bus.mlp_init_valid_o, tbl[i].e_iv);
      chk("tbl_start_valid", bus.mlp_start_valid_o, tbl[i].e_stv);
      chk("tbl_src_ready", bus.src_ready_o, tbl[i].e_sr);
      chk("tbl_busy", bus.busy_o, tbl[i].e_busy);
      chk("tbl_mlp_data", bus.mlp_data_o, tbl[i].e_md);
      tick();
    end
    bus.mlp_init_ready_i = 1'b0;
    stream(NW, -1, 1'b1);
    chk("wload_idle", bus.busy_o, 0);
    chk("wload_err", bus.err_o, 0);
    tick();
    chk("wload_done_pulse", bus.done_o, 0);

    // Inference run with a gap in the result stream
    cmd(1'b1);
    hs_start();
    stream(NX, -1, 1'b0);
    chk("rwait_src_ready", bus.src_ready_o, 0);
    chk("rwait_busy", bus.busy_o, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rwait_res_valid", bus.res_valid_o, 0);
    end
    results(10);
    chk("run_err", bus.err_o, 0);

    // Underrun at word 100, sticky error cleared by next command
    cmd(1'b1);
    hs_start();
    stream(NX, 100, 1'b0);
    chk("underrun_burst_len", bus.src_ready_o, 0);
    results(-1);
    chk("underrun_err_sticky", bus.err_o, 1);
    cmd(1'b0);

    // Reset at W_STREAM word 500
    bus.mlp_init_ready_i = 1'b1;
    #1;
    chk("init_valid_hs", bus.mlp_init_valid_o, 1);
    tick();
    bus.mlp_init_ready_i = 1'b0;
    stream(500, -1, 1'b0);
    bus.src_valid_i = 1'b1;
    bus.src_data_i  = 8'hF4;
    #1;
    chk("pre_rst_src_ready", bus.src_ready_o, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_src_ready", bus.src_ready_o, 0);
    chk("mid_rst_mlp_data", bus.mlp_data_o, 0);
    chk("mid_rst_busy", bus.busy_o, 0);
    chk("mid_rst_cmd_ready", bus.cmd_ready_o, 1);
    tick();
    rst_n = 1'b1;
    bus.src_valid_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("post_rst_no_req", {bus.mlp_init_valid_o, bus.mlp_start_valid_o, bus.busy_o}, 0);
    end
    cmd(1'b1);
    hs_start();
    stream(NX, -1, 1'b0);
    results(-1);

    // Spurious result while idle
    bus.mlp_result_valid_i = 1'b1;
    bus.mlp_result_data_i  = 8'd77;
    tick();
    bus.mlp_result_valid_i = 1'b0;
    chk("spurious_res_valid", bus.res_valid_o, 0);
    chk("spurious_err", bus.err_o, 1);
    chk("spurious_busy", bus.busy_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mlp_host_seq.md
MLP_HOST_SEQ -- requirements
Module: mlp_host_seq

Interface
REQ-001 SHALL have parameter DataWidth, 8, width of weight/activation/result words.
REQ-002 SHALL have parameter WordsW, 2048, weight words per load (8 layers x 256).
REQ-003 SHALL have parameter WordsX, 256, activation words per run and result words per run.
REQ-004 SHALL have one clock; reset is asynchronous and active-low; ports are clk_i and rst_ni.
REQ-005 Ports, one per line (name direction width meaning):
 clk_i  in  1  clock, all state on rising edge
 rst_ni  in  1  async active-low reset
 cmd_valid_i  in  1  host command valid
 cmd_ready_o  out  1  command accepted when valid&ready
 cmd_op_i  in  1  0 = load weights, 1 = run inference
 src_valid_i  in  1  source word valid
 src_ready_o  out  1  source word consumed
 src_data_i  in  DataWidth  source word (weight or activation)
 mlp_init_valid_o  out  1  weight-load request to MLP controller
 mlp_init_ready_i  in  1  controller idle, accepts init
 mlp_start_valid_o  out  1  inference request to MLP controller
 mlp_start_ready_i  in  1  controller idle, accepts start
 mlp_data_o  out  DataWidth  write data into weight/activation memory
 mlp_result_valid_i  in  1  controller streaming result, one word/cycle
 mlp_result_data_i  in  DataWidth  result word, valid with mlp_result_valid_i
 res_valid_o  out  1  registered result valid
 res_data_o  out  DataWidth  registered result word
 res_idx_o  out  8  index of res_data_o within run
 busy_o  out  1  state != IDLE
 done_o  out  1  one-cycle pulse at command completion
 err_o  out  1  sticky underrun/overrun flag

Function
REQ-006 SHALL implement states IDLE, W_REQ, W_STREAM, X_REQ, X_STREAM, R_WAIT, R_COLLECT.
REQ-007 IDLE: cmd_ready_o=1; on cmd_valid_i&cmd_ready_o go W_REQ (op 0) or X_REQ (op 1); clear err_o and word counter.
REQ-008 W_REQ: mlp_init_valid_o=1 until mlp_init_ready_i=1 in same cycle, then W_STREAM next cycle; mlp_start_valid_o never asserted here.
REQ-009 X_REQ: mlp_start_valid_o=1 until mlp_start_ready_i=1, then X_STREAM; init and start SHALL never be high together.
REQ-010 W_STREAM/X_STREAM: src_ready_o=1 every cycle; mlp_data_o=src_data_i combinationally; word k of the burst presented in k-th stream cycle (k from 0), no stall.
REQ-011 Underrun: stream cycle with src_valid_i=0 SHALL drive mlp_data_o=0, set err_o, still advance counter.
REQ-012 Word counter 11 bits; W_STREAM lasts exactly WordsW cycles then IDLE with done_o pulse; X_STREAM lasts exactly WordsX cycles then R_WAIT.
REQ-013 R_WAIT: first cycle with mlp_result_valid_i=1 enters R_COLLECT and captures that word as index 0.
REQ-014 R_WAIT/R_COLLECT: each cycle with mlp_result_valid_i=1 registers res_data_o<=mlp_result_data_i, res_valid_o<=1, res_idx_o<=result count (8-bit, wraps 255->0); else res_valid_o<=0.
REQ-015 After WordsX results captured, return to IDLE next cycle; done_o pulses in the cycle res_idx_o=WordsX-1 is presented.
REQ-016 mlp_result_valid_i high outside R_WAIT/R_COLLECT, or after WordsX results: ignored, err_o set.
REQ-017 Outside stream states src_ready_o=0 and mlp_data_o=0; cmd_ready_o=0 outside IDLE.
REQ-018 Result latency: mlp_result_* to res_* exactly one cycle; no backpressure on res_*.

Reset
REQ-019 rst_ni low SHALL asynchronously force IDLE, counters 0, all outputs 0 except cmd_ready_o=1 once in IDLE (cmd_ready_o=1 during reset).
REQ-020 Reset mid-burst SHALL abort immediately; no further mlp_* request until a new command.

Verification
REQ-021 Load weights, src always valid with data=k[7:0] -> init handshake, then 2048 consecutive cycles mlp_data_o=k[7:0], done_o once, err_o=0.
REQ-022 Init ready held low 5 cycles -> mlp_init_valid_o high 6 cycles, stream starts cycle after handshake, src_ready_o=0 during wait.
REQ-023 Run, activations 0..255, model returns 256 results r=255-i -> res_valid_o 256 cycles, res_idx_o 0..255, res_data_o=255-idx, done_o on idx 255.
REQ-024 src_valid_i dropped at word 100 of X burst -> mlp_data_o=0 that cycle, err_o=1 sticky, burst still 256 cycles; cleared by next command.
REQ-025 rst_ni asserted at W_STREAM word 500 -> outputs 0 immediately, busy_o=0; new run command proceeds normally.
REQ-026 Spurious mlp_result_valid_i in IDLE -> res_valid_o stays 0, err_o=1.
